status_cond_unit: RTL and testbench

Holds the processor status register (flags {Z,C,N,V}) fed by the ALU, evaluates the 4-bit ARM condition field of the instruction in ID against it, and issues the ID→EXE valid bit. Returns the committed carry to the ALU's C input. Detects the flag hazard between an S-instruction in EXE and a conditional instruction in ID, and stalls one cycle. Counts annulled conditional instructions for debug. Sits between the ID and EXE stages of the ARM pipeline.

---
 rtl/status_cond_unit_if.sv | 25 ++
 rtl/status_cond_unit.sv | 84 ++++++++
 tb/tb_status_cond_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/status_cond_unit_if.sv
// ID/EXE status-and-condition signal bundle: ALU flags and ID control in, flags/issue/stall out.
interface status_cond_unit_if;
   logic [3:0]  sr_in;
   logic        exe_s;
   logic        freeze;
   logic        flush;
   logic        id_valid;
   logic [3:0]  id_cond;
   logic [3:0]  sr_out;
   logic        c_flag;
   logic        cond_pass;
   logic        hazard;
   logic        exe_en;
   logic [15:0] annul_cnt;

   modport master (
      output sr_in, exe_s, freeze, flush, id_valid, id_cond,
      input  sr_out, c_flag, cond_pass, hazard, exe_en, annul_cnt
   );

   modport slave (
      input  sr_in, exe_s, freeze, flush, id_valid, id_cond,
      output sr_out, c_flag, cond_pass, hazard, exe_en, annul_cnt
   );
endinterface

// File: rtl/status_cond_unit.sv
// ARM status register {Z,C,N,V}, condition-field evaluation, ID->EXE issue and flag-hazard stall.
module status_cond_unit #(
   parameter logic [3:0] SR_RST    = 4'b0000,
   parameter bit         HAZARD_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   status_cond_unit_if.slave bus
);

   logic [3:0]  sr_q,   sr_d;
   logic        en_q,   en_d;
   logic [15:0] cnt_q,  cnt_d;

   logic        z_flag, c_bit, n_flag, v_flag;
   logic        hi_c, ge_c, gt_c;
   logic [7:0]  base_cond;
   logic [15:0] cond_vec;
   logic        cond_pass;
   logic        hazard;
   logic        issue_ok;

   assign z_flag = sr_q[3];
   assign c_bit  = sr_q[2];
   assign n_flag = sr_q[1];
   assign v_flag = sr_q[0];

   assign hi_c = c_bit & ~z_flag;
   assign ge_c = (n_flag == v_flag);
   assign gt_c = ~z_flag & ge_c;

   // Odd codes are the complement of the even code below them; NV is the complement of AL.
   assign base_cond = {1'b1, gt_c, ge_c, hi_c, v_flag, n_flag, c_bit, z_flag};

   generate
      genvar gi;
      for (gi = 0; gi < 8; gi++) begin : g_cond
         assign cond_vec[2*gi]   =  base_cond[gi];
         assign cond_vec[2*gi+1] = ~base_cond[gi];
      end
   endgenerate

   assign cond_pass = cond_vec[bus.id_cond];

   assign hazard = HAZARD_EN & bus.id_valid & (bus.id_cond != 4'b1110) & bus.exe_s;

   assign issue_ok = bus.id_valid & ~hazard & ~bus.flush;

   always_comb begin
      sr_d  = sr_q;
      en_d  = en_q;
      cnt_d = cnt_q;
      if (!bus.freeze) begin
         // SR write is independent of flush: the S-instruction in EXE still commits.
         if (bus.exe_s) begin
            sr_d = bus.sr_in;
         end
         en_d = issue_ok & cond_pass;
         if (issue_ok && !cond_pass && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr_q  <= SR_RST;
         en_q  <= 1'b0;
         cnt_q <= 16'd0;
      end else begin
         sr_q  <= sr_d;
         en_q  <= en_d;
         cnt_q <= cnt_d;
      end
   end

   assign bus.sr_out    = sr_q;
   assign bus.c_flag    = sr_q[2];
   assign bus.cond_pass = cond_pass;
   assign bus.hazard    = hazard;
   assign bus.exe_en    = en_q;
   assign bus.annul_cnt = cnt_q;

endmodule

// File: tb/tb_status_cond_unit.sv
// Directed-vector bench for status_cond_unit; expectations queued by stimulus, checked by a negedge monitor.
module tb_status_cond_unit;

   localparam int K_CP  = 0;
   localparam int K_HZ  = 1;
   localparam int K_SR  = 2;
   localparam int K_CF  = 3;
   localparam int K_EN  = 4;
   localparam int K_CNT = 5;

   typedef struct {
      string       name;
      int          kind;
      logic [15:0] exp;
   } chk_t;

   logic clk;
   logic rst_n;
   status_cond_unit_if bus();

   chk_t sb[$];
   int   n_cmp;
   int   n_bad;

   // pass_tab[sr][code]: hand-evaluated condition results for every flag value.
   logic [15:0] pass_tab [16] = '{
      16'h56AA, 16'h6A6A, 16'h6A9A, 16'h565A,
      16'h55A6, 16'h6966, 16'h6996, 16'h5556,
      16'h66A9, 16'h6A69, 16'h6A99, 16'h6659,
      16'h66A5, 16'h6A65, 16'h6A95, 16'h6655
   };

   status_cond_unit #(
      .SR_RST    (4'b0000),
      .HAZARD_EN (1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] sr_in, input logic exe_s, input logic freeze,
                        input logic flush, input logic id_valid, input logic [3:0] id_cond);
      bus.sr_in    = sr_in;
      bus.exe_s    = exe_s;
      bus.freeze   = freeze;
      bus.flush    = flush;
      bus.id_valid = id_valid;
      bus.id_cond  = id_cond;
   endtask

   task automatic expect_val(input string name, input int kind, input logic [15:0] val);
      chk_t e;
      e.name = name;
      e.kind = kind;
      e.exp  = val;
      sb.push_back(e);
   endtask

   task automatic expect_regs(input string name, input logic [3:0] sr, input logic en,
                              input logic [15:0] cnt);
      expect_val({name, " sr_out"},    K_SR,  {12'd0, sr});
      expect_val({name, " c_flag"},    K_CF,  {15'd0, sr[2]});
      expect_val({name, " exe_en"},    K_EN,  {15'd0, en});
      expect_val({name, " annul_cnt"}, K_CNT, cnt);
   endtask

   task automatic expect_comb(input string name, input logic cp, input logic hz);
      expect_val({name, " cond_pass"}, K_CP, {15'd0, cp});
      expect_val({name, " hazard"},    K_HZ, {15'd0, hz});
   endtask

   // Monitor: drains whatever the stimulus queued for this cycle.
   always @(negedge clk) begin
      chk_t        ent;
      logic [15:0] act;
      while (sb.size() > 0) begin
         ent = sb.pop_front();
         case (ent.kind)
            K_CP:    act = {15'd0, bus.cond_pass};
            K_HZ:    act = {15'd0, bus.hazard};
            K_SR:    act = {12'd0, bus.sr_out};
            K_CF:    act = {15'd0, bus.c_flag};
            K_EN:    act = {15'd0, bus.exe_en};
            default: act = bus.annul_cnt;
         endcase
         n_cmp = n_cmp + 1;
         if (act !== ent.exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h, expected %h", ent.name, act, ent.exp);
         end else begin
            $display("chk %s = %h ok", ent.name, act);
         end
      end
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      tick();
      tick();
      expect_regs("reset", 4'h0, 1'b0, 16'd0);
      tick();

      // First instruction after reset: EQ with Z=0 fails and is counted.
      rst_n = 1'b1;
      drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
      expect_comb("post-reset EQ", 1'b0, 1'b0);
      tick();
      drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      expect_regs("post-reset EQ", 4'h0, 1'b0, 16'd1);

      // Condition sweep over every flag value and every code.
      for (int s = 0; s < 16; s++) begin
         drive(4'(s), 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
         tick();
         for (int c = 0; c < 16; c++) begin
            drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(c));
            if (c == 0) expect_regs($sformatf("sweep load sr=%h", s), 4'(s), 1'b0, 16'd1);
            expect_val($sformatf("sweep sr=%h cond=%h cond_pass", s, c), K_CP,
                       {15'd0, pass_tab[s][c]});
            tick();
         end
      end

      // Flag hazard: S-instruction in EXE with EQ in ID stalls exactly one cycle.
      drive(4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      expect_regs("hz load0", 4'hF, 1'b0, 16'd1);
      tick();
      drive(4'h8, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
      expect_regs("hz stall", 4'h0, 1'b0, 16'd1);
      expect_comb("hz stall", 1'b0, 1'b1);
      tick();
      drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
      expect_regs("hz resolve", 4'h8, 1'b0, 16'd1);
      expect_comb("hz resolve", 1'b1, 1'b0);
      tick();
      drive(4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hE);
      expect_regs("hz AL", 4'h8, 1'b1, 16'd1);
      expect_comb("hz AL", 1'b1, 1'b0);
      tick();
      drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      expect_regs("hz AL issued", 4'h0, 1'b1, 16'd1);
      tick();

      // Freeze holds everything, even with exe_s, flush and a failing condition.
      drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hE);
      expect_regs("frz pre", 4'h0, 1'b0, 16'd1);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(4'h4, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF);
         expect_regs($sformatf("frz hold %0d", i), 4'h0, 1'b1, 16'd1);
         expect_comb($sformatf("frz hold %0d", i), 1'b0, 1'b1);
         tick();
      end
      drive(4'h4, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF);
      expect_regs("frz release", 4'h0, 1'b1, 16'd1);
      expect_val("frz release hazard", K_HZ, 16'd1);
      tick();

      // Flush squashes issue and annul counting.
      drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hE);
      expect_regs("frz written", 4'h4, 1'b0, 16'd1);
      expect_comb("fl pre", 1'b1, 1'b0);
      tick();
      drive(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hE);
      expect_regs("fl AL", 4'h4, 1'b1, 16'd1);
      tick();
      drive(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF);
      expect_regs("fl NV", 4'h4, 1'b0, 16'd1);
      expect_comb("fl NV", 1'b0, 1'b0);
      tick();

      // Saturation: continuous failing NV issues.
      drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF);
      expect_regs("sat start", 4'h4, 1'b0, 16'd1);
      for (int i = 0; i < 100; i++) tick();
      expect_val("sat +100", K_CNT, 16'd101);
      for (int i = 0; i < 65433; i++) tick();
      expect_val("sat FFFE", K_CNT, 16'hFFFE);
      tick();
      expect_val("sat FFFF", K_CNT, 16'hFFFF);
      for (int i = 0; i < 6; i++) tick();
      expect_regs("sat hold", 4'h4, 1'b0, 16'hFFFF);
      tick();

      // Reset with a hazard pending: registers clear, combinational outputs follow inputs.
      rst_n = 1'b0;
      drive(4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
      expect_comb("rst mid-stall", 1'b0, 1'b1);
      tick();
      expect_regs("rst mid-stall", 4'h0, 1'b0, 16'd0);
      tick();
      rst_n = 1'b1;
      drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      expect_val("rst released hazard", K_HZ, 16'd0);
      tick();

      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         $display("FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
         n_bad = n_bad + 1;
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
